// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences one shared memory
// and one ALU over 3-5 cycles per instruction, with embedded ALU decode.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Instr,
  input  logic               Zero,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCSrc,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_reg, state_next;
  logic       pc_write, branch, mem_write, ir_write, reg_write;
  logic [5:0] opcode, funct;
  logic       unused_bits;

  assign opcode      = Instr[31:26];
  assign funct       = Instr[5:0];
  assign unused_bits = ^Instr[25:6];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    Illegal    = 1'b0;
    case (state_reg)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        state_next = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here so BRANCH can use ALUOut.
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default: begin
            Illegal    = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        case (funct)
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        reg_write  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset masks every state-changing strobe so an aborted instruction writes nothing.
  assign PCEn     = ~reset & (pc_write | (branch & Zero));
  assign IRWrite  = ~reset & ir_write;
  assign RegWrite = ~reset & reg_write;
  assign MemWrite = ~reset & mem_write;
  assign State    = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes the per-cycle
// expected outputs of each instruction, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t v;
    outs_t m;
    string nm;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  outs_t act;
  outs_t full_mask;
  outs_t rst_mask;

  assign act = {State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUControl, PCSrc, Illegal};

  function automatic void push(outs_t v, outs_t m, string nm);
    exp_t e;
    e.v = v;
    e.m = m;
    e.nm = nm;
    exp_q.push_back(e);
  endfunction

  // Reference model: what each instruction class does, cycle by cycle, in datapath terms.
  function automatic int model(logic [31:0] ins, logic z);
    outs_t e;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    bit lw = (op == 6'h23), sw = (op == 6'h2B), rt = (op == 6'h00);
    bit beq = (op == 6'h04), addi = (op == 6'h08), jmp = (op == 6'h02);
    bit known = lw | sw | rt | beq | addi | jmp;
    // fetch: read memory at PC into IR, PC <= PC+4
    e = '0; e.state = 0; e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; e.aluctl = 3'b010;
    push(e, full_mask, "fetch");
    // decode: ALU forms PC + (imm<<2)
    e = '0; e.state = 1; e.alusrcb = 2'b11; e.aluctl = 3'b010; e.illegal = !known;
    push(e, full_mask, "decode");
    if (lw || sw) begin
      e = '0; e.state = 2; e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010;
      push(e, full_mask, "memadr");
      if (lw) begin
        e = '0; e.state = 3; e.iord = 1; push(e, full_mask, "memrd");
        e = '0; e.state = 4; e.memtoreg = 1; e.regwrite = 1; push(e, full_mask, "memwb");
        return 5;
      end
      e = '0; e.state = 5; e.iord = 1; e.memwrite = 1; push(e, full_mask, "memwr");
      return 4;
    end
    if (rt) begin
      e = '0; e.state = 6; e.alusrca = 1;
      e.aluctl = (fn == 6'd34) ? 3'b110 : (fn == 6'd36) ? 3'b000 :
                 (fn == 6'd37) ? 3'b001 : (fn == 6'd42) ? 3'b111 : 3'b010;
      push(e, full_mask, "execute");
      e = '0; e.state = 7; e.regdst = 1; e.regwrite = 1; push(e, full_mask, "aluwb");
      return 4;
    end
    if (beq) begin
      e = '0; e.state = 8; e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
      push(e, full_mask, "branch");
      return 3;
    end
    if (addi) begin
      e = '0; e.state = 9; e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010;
      push(e, full_mask, "addiex");
      e = '0; e.state = 10; e.regwrite = 1; push(e, full_mask, "addiwb");
      return 4;
    end
    if (jmp) begin
      e = '0; e.state = 11; e.pcsrc = 2'b10; e.pcen = 1; push(e, full_mask, "jump");
      return 3;
    end
    return 2;
  endfunction

  function automatic void push_reset(logic [3:0] st);
    outs_t e;
    e = '0;
    e.state = st;
    push(e, rst_mask, "reset");
  endfunction

  // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z);
    int n;
    n = model(ins, z);
    Instr = ins;
    Zero = z;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s cyc=%0d state got=%0d exp=%0d outputs got=%h exp=%h mask=%h",
                 e.nm, cyc, State, e.v.state, act & e.m, e.v & e.m, e.m);
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    logic [5:0]  op;
    logic [5:0]  fns[6];
    fns[0] = 6'd32; fns[1] = 6'd34; fns[2] = 6'd36; fns[3] = 6'd37; fns[4] = 6'd42;
    fns[5] = 6'($urandom_range(0, 63));
    case ($urandom_range(0, 6))
      0: op = 6'h23;
      1: op = 6'h2B;
      2: begin op = 6'h00; ins[5:0] = fns[$urandom_range(0, 5)]; end
      3: op = 6'h04;
      4: op = 6'h08;
      5: op = 6'h02;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 ||
               op == 6'h08 || op == 6'h02)
          op = 6'($urandom_range(0, 63));
      end
    endcase
    ins[31:26] = op;
    return ins;
  endfunction

  initial begin
    int n;
    full_mask = '1;
    rst_mask = '0;
    rst_mask.state = '1;
    rst_mask.pcen = 1; rst_mask.memwrite = 1; rst_mask.irwrite = 1; rst_mask.regwrite = 1;

    reset = 1'b1;
    Instr = 32'h0;
    Zero  = 1'b0;
    @(posedge clk); #1;
    push_reset(4'd0);
    @(posedge clk); #1;
    push_reset(4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(32'h8C43_0008, 1'b0);           // lw
    run_instr(32'h0043_2022, 1'b1);           // sub
    run_instr(32'h1043_0004, 1'b1);           // beq taken
    run_instr(32'h1043_0004, 1'b0);           // beq not taken
    run_instr(32'h0800_0010, 1'b0);           // j
    run_instr(32'hFC00_0000, 1'b0);           // illegal 0x3F
    run_instr(32'hAC43_0004, 1'b0);           // sw
    run_instr(32'h2043_0005, 1'b0);           // addi

    // sw aborted by a 3-cycle reset asserted during MEMWR
    Instr = 32'hAC43_0004;
    n = model(Instr, 1'b0);
    void'(exp_q.pop_back());                  // MEMWR is replaced by the reset cycles
    repeat (n - 1) @(posedge clk);
    #1;
    reset = 1'b1;
    push_reset(4'd5);
    @(posedge clk); #1;
    push_reset(4'd0);
    @(posedge clk); #1;
    push_reset(4'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(32'h0800_0010, 1'b0);           // FETCH right after release: IRWrite=1, PCEn=1

    for (int i = 0; i < 150; i++)
      run_instr(rand_instr(), 1'($urandom_range(0, 1)));

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
